// File: rtl/category_argmax_seq_if.sv
// category_argmax_seq_if: beat input and result output handshakes of the
// sequential classifier head.
//   master: producer/consumer side (drives in_valid, in_bits, out_ready)
//   slave : classifier side (drives in_ready, out_valid, out_index,
//           out_value, out_margin)
interface category_argmax_seq_if #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 256,
  parameter int CHUNK             = 32
);
  localparam int SUM_W = $clog2(BITS_PER_CATEGORY + 1);
  localparam int IDX_W = $clog2(CATEGORIES);

  logic                        in_valid;
  logic                        in_ready;
  logic [CATEGORIES*CHUNK-1:0] in_bits;
  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            out_index;
  logic [SUM_W-1:0]            out_value;
  logic [SUM_W-1:0]            out_margin;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_margin
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_index, out_value, out_margin
  );
endinterface

// File: rtl/category_argmax_seq.sv
// category_argmax_seq: accumulates per-category popcounts over BEATS beats of
// CHUNK bits each, then scans the categories one per cycle for the winner and
// runner-up and presents index / score / margin behind a valid/ready handshake.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous frame abort (beats and pending result discarded)
//   bus   : slave side of category_argmax_seq_if (beat in, result out)

// One accumulator lane: popcount of this category's chunk added per beat.
module category_argmax_lane #(
  parameter int CHUNK = 32,
  parameter int SUM_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [CHUNK-1:0] bits,
  output logic [SUM_W-1:0] acc
);
  logic [SUM_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHUNK; i++) pop = pop + SUM_W'(bits[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= acc + pop;
  end
endmodule

module category_argmax_seq #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 256,
  parameter int CHUNK             = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  category_argmax_seq_if.slave bus
);
  localparam int BEATS = BITS_PER_CATEGORY / CHUNK;
  localparam int SUM_W = $clog2(BITS_PER_CATEGORY + 1);
  localparam int IDX_W = $clog2(CATEGORIES);
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                       state;
  logic [BC_W-1:0]                  beat_cnt;
  logic [IDX_W-1:0]                 scan_idx, best_idx;
  logic [SUM_W-1:0]                 best, second, scan_val;
  logic [CATEGORIES-1:0][SUM_W-1:0] acc;
  logic                             take, acc_clr, acc_add;

  // in_ready is pure state decode, so a beat is taken whenever one is offered
  // in ACCUM; flush wins over the beat.
  assign take    = bus.in_valid && (state == S_ACCUM);
  assign acc_add = take && !flush;
  assign acc_clr = flush || ((state == S_DONE) && bus.out_ready);

  for (genvar g = 0; g < CATEGORIES; g++) begin : g_lane
    category_argmax_lane #(.CHUNK(CHUNK), .SUM_W(SUM_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr),
      .add  (acc_add),
      .bits (bus.in_bits[g*CHUNK +: CHUNK]),
      .acc  (acc[g])
    );
  end

  assign scan_val = acc[scan_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_ACCUM;
      beat_cnt <= '0;
      scan_idx <= '0;
      best_idx <= '0;
      best     <= '0;
      second   <= '0;
    end else if (flush) begin
      state    <= S_ACCUM;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_ACCUM: if (take) begin
          if (beat_cnt == BC_W'(BEATS - 1)) begin
            beat_cnt <= '0;
            state    <= S_SCAN;
            scan_idx <= '0;
            best_idx <= '0;
            best     <= '0;
            second   <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        S_SCAN: begin
          // Strict '>' keeps the lowest index on ties; the tied score then
          // lands in second, giving margin 0.
          if (scan_val > best) begin
            second   <= best;
            best     <= scan_val;
            best_idx <= scan_idx;
          end else if (scan_val >= second) begin
            second <= scan_val;
          end
          if (scan_idx == IDX_W'(CATEGORIES - 1)) state <= S_DONE;
          else                                    scan_idx <= scan_idx + 1'b1;
        end
        S_DONE: if (bus.out_ready) state <= S_ACCUM;
        default: state <= S_ACCUM;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_ACCUM);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.out_index  = best_idx;
  assign bus.out_value  = best;
  assign bus.out_margin = best - second;
endmodule

// File: tb/tb_category_argmax_seq.sv
// Randomized bench for category_argmax_seq with a score-level reference model.
module tb_category_argmax_seq;
  localparam int C     = 10;
  localparam int B     = 256;
  localparam int CH    = 32;
  localparam int BEATS = B / CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  category_argmax_seq_if #(.CATEGORIES(C), .BITS_PER_CATEGORY(B), .CHUNK(CH)) bif ();

  category_argmax_seq #(.CATEGORIES(C), .BITS_PER_CATEGORY(B), .CHUNK(CH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int         sc [C];
  logic [B-1:0] fr [C];
  int exp_idx, exp_val, exp_mar;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: winner is the lowest index holding the maximum; runner-up is
  // the maximum over every other category.
  task automatic model();
    exp_idx = 0;
    for (int c = 1; c < C; c++) if (sc[c] > sc[exp_idx]) exp_idx = c;
    exp_val = sc[exp_idx];
    exp_mar = exp_val;
    begin
      int sec = 0;
      for (int c = 0; c < C; c++) if (c != exp_idx && sc[c] > sec) sec = sc[c];
      exp_mar = exp_val - sec;
    end
  endtask

  // Spread each category's score as randomly placed ones across the frame.
  task automatic build_frame();
    for (int c = 0; c < C; c++) begin
      logic [B-1:0] v;
      v = '0;
      for (int i = 0; i < sc[c]; i++) v[i] = 1'b1;
      for (int i = B - 1; i > 0; i--) begin
        int  j;
        logic t;
        j = $urandom_range(i, 0);
        t = v[i]; v[i] = v[j]; v[j] = t;
      end
      fr[c] = v;
    end
  endtask

  task automatic send_beats(input int gap_pct, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      while (int'($urandom_range(99, 0)) < gap_pct) begin
        bif.in_valid = 1'b0;
        bif.in_bits  = {C*CH{1'b1}};
        tick();
      end
      for (int c = 0; c < C; c++) bif.in_bits[c*CH +: CH] = fr[c][b*CH +: CH];
      bif.in_valid = 1'b1;
      chk("in_ready_accum", int'(bif.in_ready), 1);
      tick();
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, output int lat);
    model();
    lat = 0;
    while (!bif.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"},  int'(bif.out_valid),  1);
    chk({tag, "_index"},  int'(bif.out_index),  exp_idx);
    chk({tag, "_value"},  int'(bif.out_value),  exp_val);
    chk({tag, "_margin"}, int'(bif.out_margin), exp_mar);
  endtask

  task automatic release_result(input string tag);
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk({tag, "_rel_valid"}, int'(bif.out_valid), 0);
    chk({tag, "_rel_ready"}, int'(bif.in_ready), 1);
  endtask

  task automatic set_scores(input int v0, input int v1, input int v2, input int v3);
    for (int c = 0; c < C; c++) sc[c] = 0;
    // v0 is a category index, v1 its score; v2 index, v3 score (v2<0 skips)
    sc[v0] = v1;
    if (v2 >= 0) sc[v2] = v3;
  endtask

  initial begin
    int lat;
    int hold_idx, hold_val, hold_mar;
    bif.in_valid  = 1'b0;
    bif.in_bits   = '0;
    bif.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid",  int'(bif.out_valid),  0);
    chk("rst_ready",  int'(bif.in_ready),   1);
    chk("rst_index",  int'(bif.out_index),  0);
    chk("rst_value",  int'(bif.out_value),  0);
    chk("rst_margin", int'(bif.out_margin), 0);

    // Class 3 all ones, back-to-back beats, latency and backpressure.
    set_scores(3, 256, -1, 0);
    build_frame();
    send_beats(0, BEATS);
    expect_result("c3", lat);
    chk("c3_latency", lat, C);
    hold_idx = int'(bif.out_index);
    hold_val = int'(bif.out_value);
    hold_mar = int'(bif.out_margin);
    for (int k = 0; k < 5; k++) begin
      bif.in_valid = 1'b1;
      bif.in_bits  = {C*CH{1'b1}};
      tick();
      chk("bp_valid",  int'(bif.out_valid), 1);
      chk("bp_ready",  int'(bif.in_ready), 0);
      chk("bp_index",  int'(bif.out_index),  hold_idx);
      chk("bp_value",  int'(bif.out_value),  hold_val);
      chk("bp_margin", int'(bif.out_margin), hold_mar);
    end
    bif.in_valid = 1'b0;
    release_result("c3");

    // Tie: 2 and 7 at 100, 5 at 60.
    set_scores(2, 100, 7, 100);
    sc[5] = 60;
    build_frame();
    send_beats(0, BEATS);
    expect_result("tie", lat);
    release_result("tie");

    // Margin of one: 9=200 beats 0=199.
    set_scores(9, 200, 0, 199);
    build_frame();
    send_beats(0, BEATS);
    expect_result("m1", lat);
    release_result("m1");

    // Class 3 all ones again with random gaps.
    set_scores(3, 256, -1, 0);
    build_frame();
    send_beats(40, BEATS);
    expect_result("gap", lat);
    release_result("gap");

    // Reset mid-frame, then class 1 = 17.
    for (int c = 0; c < C; c++) sc[c] = $urandom_range(B, 0);
    build_frame();
    send_beats(0, 4);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("mid_rst_valid", int'(bif.out_valid), 0);
    chk("mid_rst_ready", int'(bif.in_ready), 1);
    set_scores(1, 17, -1, 0);
    build_frame();
    send_beats(20, BEATS);
    expect_result("after_rst", lat);
    release_result("after_rst");

    // Same with flush; the beat offered alongside flush must be dropped.
    for (int c = 0; c < C; c++) sc[c] = $urandom_range(B, 0);
    build_frame();
    send_beats(0, 4);
    flush = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_bits  = {C*CH{1'b1}};
    tick();
    flush = 1'b0;
    bif.in_valid = 1'b0;
    set_scores(1, 17, -1, 0);
    build_frame();
    send_beats(20, BEATS);
    expect_result("after_flush", lat);
    release_result("after_flush");

    // Flush while the result is pending.
    for (int c = 0; c < C; c++) sc[c] = $urandom_range(B, 0);
    build_frame();
    send_beats(0, BEATS);
    expect_result("pre_flush", lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_valid", int'(bif.out_valid), 0);
    chk("done_flush_ready", int'(bif.in_ready), 1);
    for (int c = 0; c < C; c++) sc[c] = $urandom_range(B, 0);
    build_frame();
    send_beats(0, BEATS);
    expect_result("post_flush", lat);
    release_result("post_flush");

    // Random frames, some with forced ties, random consumer stalls.
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < C; c++) sc[c] = $urandom_range(B, 0);
      if (it % 2 == 1) sc[$urandom_range(C-1, 0)] = sc[$urandom_range(C-1, 0)];
      if (it == 6) for (int c = 0; c < C; c++) sc[c] = 0;
      build_frame();
      send_beats(30, BEATS);
      expect_result("rand", lat);
      for (int k = 0; k < int'($urandom_range(3, 0)); k++) tick();
      release_result("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
